txd_arbiter: RTL



---
 rtl/txd_arbiter_if.sv | 54 +++++
 rtl/txd_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/txd_arbiter_if.sv
// -----------------------------------------------------------------------------
// txd_arbiter_if
//
// Bundles every signal between the UART TX arbiter and its surroundings: the
// two requester byte streams, the UART transmitter holding-register handshake
// and the arbiter status outputs.
//
// Signals:
//   req0_data/valid/last  requester 0 (CPU console) byte stream
//   req0_ready            requester 0 byte accepted
//   req1_data/valid/last  requester 1 (status reporter) byte stream
//   req1_ready            requester 1 byte accepted
//   tx_data/tx_valid      byte to the UART transmitter
//   tx_ready              UART transmitter can accept a byte
//   grant                 one-hot current owner, 2'b00 when idle
//   timeout_pulse         one-cycle strobe when a grant is revoked by timeout
//
// Modports:
//   slave   the arbiter itself
//   master  the environment (requesters plus UART transmitter)
// -----------------------------------------------------------------------------
interface txd_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] grant;
  logic       timeout_pulse;

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_data, tx_valid,
    output grant, timeout_pulse
  );

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_data, tx_valid,
    input  grant, timeout_pulse
  );
endinterface

// File: rtl/txd_arbiter.sv
// -----------------------------------------------------------------------------
// txd_arbiter
//
// Shares the single UART TX byte interface between the CPU console stream
// (requester 0) and the board status reporter (requester 1). Ownership is
// granted for a whole packet, alternates round-robin, and is reclaimed if the
// owner goes C_TIMEOUT cycles without a transfer, so neither stream can lock
// the TXD line.
//
// Parameters:
//   C_TIMEOUT  transfer-free cycles allowed before a grant is revoked
//              (default 12000 = 1 ms at 12 MHz, legal 2 .. 2**24)
//
// Ports:
//   CLK12MHZ   system clock
//   reset      synchronous, active-high
//   bus        txd_arbiter_if.slave: requester streams, UART handshake,
//              grant and timeout_pulse status
//
// The data path is a combinational mux selected by the registered state;
// grant and timeout_pulse come straight from flops.
// -----------------------------------------------------------------------------
module txd_arbiter #(
  parameter int unsigned C_TIMEOUT = 12000
) (
  input  logic          CLK12MHZ,
  input  logic          reset,
  txd_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(C_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_TIMEOUT - 1);

  // Encoding chosen so the state register doubles as the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state;
  logic          prio;            // 0 favours requester 0 on a tie
  logic [CW-1:0] cnt;             // transfer-free cycles in the current grant
  logic          timeout_pulse_q;

  logic [7:0]    tx_data_c;
  logic          tx_valid_c;
  logic          req0_ready_c;
  logic          req1_ready_c;
  logic          cur_last;
  logic          xfer;

  // Pass-through mux from the owning requester to the UART.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a value unassigned and infer a latch.
    tx_data_c    = 8'h00;
    tx_valid_c   = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    cur_last     = 1'b0;
    case (state)
      GNT0: begin
        tx_data_c    = bus.req0_data;
        tx_valid_c   = bus.req0_valid;
        req0_ready_c = bus.tx_ready;
        cur_last     = bus.req0_last;
      end
      GNT1: begin
        tx_data_c    = bus.req1_data;
        tx_valid_c   = bus.req1_valid;
        req1_ready_c = bus.tx_ready;
        cur_last     = bus.req1_last;
      end
      default: ;
    endcase
  end

  // tx_valid_c is zero in IDLE, so this is the owner's valid & ready.
  assign xfer = tx_valid_c & bus.tx_ready;

  always_ff @(posedge CLK12MHZ) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state           <= IDLE;
      prio            <= 1'b0;
      cnt             <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req0_valid && (!bus.req1_valid || !prio)) state <= GNT0;
          else if (bus.req1_valid)                          state <= GNT1;
        end
        GNT0, GNT1: begin
          if (xfer) begin
            // A transfer always beats a coinciding timeout.
            cnt <= '0;
            if (cur_last) begin
              state <= IDLE;
              prio  <= (state == GNT0);
            end
          end else if (cnt == CNT_MAX) begin
            state           <= IDLE;
            prio            <= (state == GNT0);
            timeout_pulse_q <= 1'b1;
            cnt             <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data       = tx_data_c;
  assign bus.tx_valid      = tx_valid_c;
  assign bus.req0_ready    = req0_ready_c;
  assign bus.req1_ready    = req1_ready_c;
  assign bus.grant         = state;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule
